// File: rtl/onehot_enc_pkg.sv
// Shared mode constants and width helper for the one-hot to binary encoder.
// The encoder core and the pipelined top both import this package.
package onehot_enc_pkg;

    localparam bit STRICT_OFF = 1'b0;
    localparam bit STRICT_ON  = 1'b1;

    localparam bit PRIO_LSB = 1'b0;
    localparam bit PRIO_MSB = 1'b1;

    // Number of bits needed to index n lines; never below 1.
    function automatic int enc_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/onehot_enc_core.sv
// Purely combinational encoder: in_code -> {bin, err, none}.
// Strict mode flags anything not exactly one-hot; otherwise priority-encodes.
import onehot_enc_pkg::*;

module onehot_enc_core #(
    parameter int N_IN         = 10,
    parameter int OUT_W        = enc_width(N_IN),
    parameter bit STRICT       = STRICT_ON,
    parameter bit PRIORITY_MSB = PRIO_LSB
) (
    input  logic [N_IN-1:0]  code,
    output logic [OUT_W-1:0] bin,
    output logic             err,
    output logic             none
);

    logic [OUT_W-1:0] lo_idx;
    logic [OUT_W-1:0] hi_idx;
    logic             seen;
    logic             multi;

    // NOTE: every signal written here gets a default first; otherwise a
    // path that skips an assignment would infer a latch.
    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        seen   = 1'b0;
        multi  = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (code[i]) begin
                if (seen) begin
                    multi = 1'b1;
                end
                seen   = 1'b1;
                hi_idx = OUT_W'(i);
            end
        end
        // Scanning downward leaves the lowest set index in lo_idx.
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (code[i]) begin
                lo_idx = OUT_W'(i);
            end
        end
    end

    always_comb begin
        none = ~seen;
        err  = 1'b0;
        bin  = '0;
        if (STRICT) begin
            err = none | multi;
            if (!err) begin
                bin = lo_idx;
            end
        end else begin
            bin = PRIORITY_MSB ? hi_idx : lo_idx;
        end
    end

endmodule

// File: rtl/onehot_to_bin_encoder_pipe.sv
// Registered one-hot/priority encoder with a valid/ready output stage
// and a saturating count of erroring words.
import onehot_enc_pkg::*;

module onehot_to_bin_encoder_pipe #(
    parameter int N_IN         = 10,
    parameter int OUT_W        = enc_width(N_IN),
    parameter bit STRICT       = STRICT_ON,
    parameter bit PRIORITY_MSB = PRIO_LSB,
    parameter int ERR_CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_IN-1:0]      in_code,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_bin,
    output logic                 out_err,
    output logic                 out_none,
    input  logic                 clr_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    logic [0:0]       state;
    logic             accept;
    logic [OUT_W-1:0] enc_bin;
    logic             enc_err;
    logic             enc_none;

    onehot_enc_core #(
        .N_IN         (N_IN),
        .OUT_W        (OUT_W),
        .STRICT       (STRICT),
        .PRIORITY_MSB (PRIORITY_MSB)
    ) u_core (
        .code (in_code),
        .bin  (enc_bin),
        .err  (enc_err),
        .none (enc_none)
    );

    assign out_valid = (state == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else if (state == ST_EMPTY) begin
            if (accept) begin
                state <= ST_FULL;
            end
        end else if (out_ready && !accept) begin
            state <= ST_EMPTY;
        end
    end

    // Output fields only move on accept, which keeps them stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_bin  <= '0;
            out_err  <= 1'b0;
            out_none <= 1'b0;
        end else if (accept) begin
            out_bin  <= enc_bin;
            out_err  <= enc_err;
            out_none <= enc_none;
        end
    end

    // Clear takes precedence over a coincident erroring accept.
    always_ff @(posedge clk) begin
        if (rst || clr_err) begin
            err_count <= '0;
        end else if (accept && enc_err && (err_count != ERR_MAX)) begin
            err_count <= err_count + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_onehot_to_bin_encoder_pipe.sv
// Directed bench: four encoder configurations share one stimulus stream.
// a = strict/8-bit count, l = priority LSB, m = priority MSB, s = strict/2-bit count.
module tb_onehot_to_bin_encoder_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [9:0] in_code;
    logic       out_ready;
    logic       clr_err;

    logic       a_in_ready, a_out_valid, a_out_err, a_out_none;
    logic [3:0] a_out_bin;
    logic [7:0] a_err_count;
    logic       l_in_ready, l_out_valid, l_out_err, l_out_none;
    logic [3:0] l_out_bin;
    logic [7:0] l_err_count;
    logic       m_in_ready, m_out_valid, m_out_err, m_out_none;
    logic [3:0] m_out_bin;
    logic [7:0] m_err_count;
    logic       s_in_ready, s_out_valid, s_out_err, s_out_none;
    logic [3:0] s_out_bin;
    logic [1:0] s_err_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    onehot_to_bin_encoder_pipe #(.N_IN(10), .OUT_W(4), .STRICT(1'b1), .PRIORITY_MSB(1'b0), .ERR_CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_code(in_code),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_bin(a_out_bin), .out_err(a_out_err),
        .out_none(a_out_none), .clr_err(clr_err), .err_count(a_err_count));

    onehot_to_bin_encoder_pipe #(.N_IN(10), .OUT_W(4), .STRICT(1'b0), .PRIORITY_MSB(1'b0), .ERR_CNT_W(8)) dut_l (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_in_ready), .in_code(in_code),
        .out_valid(l_out_valid), .out_ready(out_ready), .out_bin(l_out_bin), .out_err(l_out_err),
        .out_none(l_out_none), .clr_err(clr_err), .err_count(l_err_count));

    onehot_to_bin_encoder_pipe #(.N_IN(10), .OUT_W(4), .STRICT(1'b0), .PRIORITY_MSB(1'b1), .ERR_CNT_W(8)) dut_m (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready), .in_code(in_code),
        .out_valid(m_out_valid), .out_ready(out_ready), .out_bin(m_out_bin), .out_err(m_out_err),
        .out_none(m_out_none), .clr_err(clr_err), .err_count(m_err_count));

    onehot_to_bin_encoder_pipe #(.N_IN(10), .OUT_W(4), .STRICT(1'b1), .PRIORITY_MSB(1'b0), .ERR_CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_code(in_code),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_bin(s_out_bin), .out_err(s_out_err),
        .out_none(s_out_none), .clr_err(clr_err), .err_count(s_err_count));

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle so outputs are sampled away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [9:0] code);
        in_code  = code;
        in_valid = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_code = '0; out_ready = 1'b1; clr_err = 1'b0;

        // Reset
        tick(); tick();
        check("rst_valid", int'(a_out_valid), 0);
        check("rst_bin", int'(a_out_bin), 0);
        check("rst_cnt", int'(a_err_count), 0);
        rst = 1'b0;
        #1;
        check("rst_ready", int'(a_in_ready), 1);

        // Back-to-back one-hot sweep, one result per cycle
        for (int i = 0; i < 10; i++) begin
            send(10'(1 << i));
            check($sformatf("sweep_valid_%0d", i), int'(a_out_valid), 1);
            check($sformatf("sweep_bin_%0d", i), int'(a_out_bin), i);
            check($sformatf("sweep_err_%0d", i), int'(a_out_err), 0);
            check($sformatf("sweep_msb_bin_%0d", i), int'(m_out_bin), i);
        end
        in_valid = 1'b0;
        tick();
        check("drain_valid", int'(a_out_valid), 0);

        // Backpressure hold
        send(10'h004);
        check("bp_first", int'(a_out_bin), 2);
        out_ready = 1'b0;
        in_code   = 10'h200;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("bp_hold_bin_%0d", i), int'(a_out_bin), 2);
            check($sformatf("bp_hold_valid_%0d", i), int'(a_out_valid), 1);
            check($sformatf("bp_hold_ready_%0d", i), int'(a_in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_bin", int'(a_out_bin), 9);
        in_valid = 1'b0;
        tick();
        check("bp_empty", int'(a_out_valid), 0);

        // Strict errors vs priority encoding
        send(10'b0000000101);
        check("s101_err", int'(a_out_err), 1);
        check("s101_bin", int'(a_out_bin), 0);
        check("s101_cnt", int'(a_err_count), 1);
        check("l101_bin", int'(l_out_bin), 0);
        check("l101_err", int'(l_out_err), 0);
        check("m101_bin", int'(m_out_bin), 2);
        send(10'h000);
        check("zero_none", int'(a_out_none), 1);
        check("zero_err", int'(a_out_err), 1);
        check("zero_cnt", int'(a_err_count), 2);
        check("zero_lsb_none", int'(l_out_none), 1);
        check("zero_lsb_err", int'(l_out_err), 0);
        check("zero_lsb_cnt", int'(l_err_count), 0);
        send(10'b0100000101);
        check("lsb_prio_bin", int'(l_out_bin), 0);
        check("lsb_prio_err", int'(l_out_err), 0);
        check("msb_prio_bin", int'(m_out_bin), 8);
        check("msb_prio_err", int'(m_out_err), 0);
        check("cnt3_a", int'(a_err_count), 3);
        check("cnt3_s", int'(s_err_count), 3);

        // Saturation of the 2-bit counter
        send(10'h3FF);
        check("sat4_s", int'(s_err_count), 3);
        send(10'h000);
        check("sat5_s", int'(s_err_count), 3);
        check("cnt5_a", int'(a_err_count), 5);

        // Clear wins over a coincident erroring accept
        clr_err = 1'b1;
        send(10'h003);
        check("clr_a", int'(a_err_count), 0);
        check("clr_s", int'(s_err_count), 0);
        check("clr_word_err", int'(a_out_err), 1);
        clr_err = 1'b0;
        send(10'h000);
        check("post_clr_a", int'(a_err_count), 1);

        // Reset discards a word held under backpressure
        send(10'h020);
        check("pre_rst_bin", int'(a_out_bin), 5);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        tick();
        check("pre_rst_held", int'(a_out_valid), 1);
        rst = 1'b1;
        tick();
        check("bp_rst_valid", int'(a_out_valid), 0);
        check("bp_rst_bin", int'(a_out_bin), 0);
        check("bp_rst_cnt", int'(a_err_count), 0);
        rst = 1'b0;
        #1;
        check("bp_rst_ready", int'(a_in_ready), 1);
        tick();
        check("bp_rst_stays_empty", int'(a_out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
